pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register for the MIPS datapath. It is the successor to the fixed 32-bit load-enable stage registers between IF/ID/EX/MEM/WB.
- Adds valid/ready handshake, a 2-entry skid buffer so the stage sustains full throughput without a combinational ready path, a synchronous flush for branch/exception squash, and bubble (NOP) insertion.
- One instance sits between each pair of pipeline stages, carrying the packed stage payload.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- NOP_VAL, 0 (WIDTH bits), value presented on out_data whenever the stage holds no valid entry (bubble); 0 = MIPS sll $0,$0,0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept; registered (no combinational path from out_ready).
- in_data  input  WIDTH  upstream payload.
- flush  input  1  synchronous squash of all held entries.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload to downstream; NOP_VAL when out_valid=0.

Behaviour:
- Storage: main register (m_valid, m_data) drives the outputs; skid register (s_valid, s_data) catches one extra entry.
- Derived signals: in_ready = ~s_valid (registered state). out_valid = m_valid. out_data = m_data if m_valid else NOP_VAL.
- acc = in_valid & in_ready; pop = m_valid & out_ready.
- Reset (async): m_valid=0, s_valid=0, m_data=s_data=NOP_VAL. Therefore out_valid=0, out_data=NOP_VAL, in_ready=1.
- Latency: an entry accepted at edge N appears on out_data after edge N (1 cycle). Throughput is 1 entry/cycle while out_ready=1.
- Update rules per rising edge, flush=0:
  - m empty, acc: m <= in; s unchanged (empty).
  - m full, pop, s empty: m_valid <= acc, m_data <= in_data if acc.
  - m full, pop, s full: m <= s; s_valid <= 0. acc is impossible (in_ready=0).
  - m full, no pop, acc: s <= in, s_valid <= 1, so in_ready=0 next cycle.
  - m full, no pop, no acc: hold.
- Ordering: strict FIFO; the skid entry is always older than any later input.
- Flush has priority over everything:
  - m_valid <= 0, s_valid <= 0, m_data <= NOP_VAL.
  - Any input presented in the flush cycle is dropped, even if acc=1.
  - A pop in the flush cycle is still a valid downstream transfer of the current m_data.
  - in_ready=1 the cycle after.
- Data registers load only when their valid loads; they never change while holding an unconsumed entry.
- Reset mid-operation discards all entries immediately (asynchronous).
- No payload interpretation; WIDTH is arbitrary.

Optional Feature:
Macro: PIPE_STAGE_STATS_EN.
- Defined: adds outputs xfer_count[31:0] and stall_count[31:0].
  - xfer_count increments on each pop.
  - stall_count increments each cycle with out_valid=1 and out_ready=0.
  - Both reset to 0 on rst only (flush does not clear them) and wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset check: assert rst mid-cycle -> out_valid=0, out_data=0x00000000 (NOP_VAL), in_ready=1 immediately, with no clock required.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each; in_ready stays 1.
- Backpressure/skid: push 0xA1,0xA2 with out_ready=0 -> out_data=0xA1, in_ready=0, 0xA3 held upstream. Raise out_ready -> outputs 0xA1,0xA2,0xA3 in order, none lost or duplicated.
- Flush: stage holds 0xB1 (main) and 0xB2 (skid), flush=1 while in_valid=1 with 0xB3 -> next cycle out_valid=0, out_data=NOP_VAL, in_ready=1; 0xB3 never appears.
- Bubble: WIDTH=8, NOP_VAL=8'hFF, idle -> out_data=0xFF. Push 0x05 -> 0x05 for one cycle, then back to 0xFF.
- Stats (PIPE_STAGE_STATS_EN): 3 transfers plus 4 stalled cycles -> xfer_count=3, stall_count=4; a flush leaves both unchanged.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready stage register with 2-entry skid, flush and NOP bubble.
// Define PIPE_STAGE_STATS_EN to add xfer_count/stall_count outputs.
module pipe_stage_skid #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]      xfer_count,
  output logic [31:0]      stall_count
`endif
);
  logic m_valid, s_valid, acc, pop, m_load, s_load, m_valid_nx, s_valid_nx;
  logic [WIDTH-1:0] m_data, s_data;
  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_valid ? m_data : NOP_VAL;
  always_comb begin
    acc        = in_valid & in_ready;
    pop        = m_valid & out_ready;
    m_load     = m_valid ? pop & (s_valid | acc) : acc;
    s_load     = m_valid & ~pop & acc;
    m_valid_nx = m_valid ? ~pop | s_valid | acc : acc;
    s_valid_nx = s_load | (s_valid & ~pop);
  end
  // the skid entry is always older than in_data, so it refills main first
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= NOP_VAL;
      s_data  <= NOP_VAL;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= NOP_VAL;
    end else begin
      m_valid <= m_valid_nx;
      s_valid <= s_valid_nx;
      if (m_load) m_data <= s_valid ? s_data : in_data;
      if (s_load) s_data <= in_data;
    end
`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      xfer_count  <= '0;
      stall_count <= '0;
    end else begin
      if (pop) xfer_count <= xfer_count + 32'd1;
      if (m_valid & ~out_ready) stall_count <= stall_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid plus an 8-bit bubble instance.
module tb_pipe_stage_skid;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [31:0] in_data = '0, out_data;
  logic b_in_valid = 0, b_in_ready, b_out_valid;
  logic [7:0] b_in_data = '0, b_out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] xfer_count, stall_count;
`endif
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  always #5 clk = ~clk;
  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_STATS_EN
    , .xfer_count(xfer_count), .stall_count(stall_count)
`endif
  );
  pipe_stage_skid #(.WIDTH(8), .NOP_VAL(8'hFF)) bub (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(1'b0), .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data)
`ifdef PIPE_STAGE_STATS_EN
    , .xfer_count(), .stall_count()
`endif
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // drive one entry; the expected value is queued at the negedge before the accepting edge
  task automatic send(input logic [31:0] d);
    in_valid = 1;
    in_data = d;
    for (int i = 0; i < 50 && !(in_ready === 1'b1); i++) @(negedge clk);
    if (in_ready !== 1'b1) @(negedge clk);
    if (in_ready !== 1'b1) check("send_timeout", 32'(in_ready), 32'd1);
    else q.push_back(d);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", out_data, 32'hDEAD_BEEF);
        else check("out_data", out_data, q.pop_front());
      end else if (!out_valid) check("nop_idle", out_data, 32'h0);
    end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #11 rst = 0;
    idle(1);
    // async reset mid-cycle with an entry held
    send(32'h77);
    check("held_valid", 32'(out_valid), 32'd1);
    @(negedge clk) #2 rst = 1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", out_data, 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    idle(1);
    rst = 0;
    // streaming
    out_ready = 1;
    send(32'h11);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", out_data, 32'h11);
    check("stream_rdy1", 32'(in_ready), 32'd1);
    send(32'h22);
    check("stream_rdy2", 32'(in_ready), 32'd1);
    send(32'h33);
    check("stream_rdy3", 32'(in_ready), 32'd1);
    idle(3);
    // backpressure into the skid
    out_ready = 0;
    send(32'hA1);
    send(32'hA2);
    in_valid = 1;
    in_data = 32'hA3;
    idle(1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_data", out_data, 32'hA1);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1;
    send(32'hA3);
    idle(4);
    check("bp_drained", q.size(), 32'd0);
    // flush with main+skid full and a live input
    out_ready = 0;
    send(32'hB1);
    send(32'hB2);
    in_valid = 1;
    in_data = 32'hB3;
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    in_valid = 0;
    q.delete();
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_out_data", out_data, 32'h0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1;
    idle(2);
    check("fl_no_b3", 32'(out_valid), 32'd0);
    send(32'hC1);
    idle(3);
    check("fl_drained", q.size(), 32'd0);
    // bubble on the 8-bit instance
    check("bub_idle", 32'(b_out_data), 32'hFF);
    b_in_valid = 1;
    b_in_data = 8'h05;
    idle(1);
    b_in_valid = 0;
    check("bub_data", 32'(b_out_data), 32'h05);
    check("bub_valid", 32'(b_out_valid), 32'd1);
    idle(1);
    check("bub_back", 32'(b_out_data), 32'hFF);
    check("bub_nvalid", 32'(b_out_valid), 32'd0);
`ifdef PIPE_STAGE_STATS_EN
    rst = 1;
    #2 rst = 0;
    check("st_rst_x", xfer_count, 32'd0);
    check("st_rst_s", stall_count, 32'd0);
    idle(1);
    out_ready = 0;
    send(32'h1);
    idle(4);
    out_ready = 1;
    send(32'h2);
    send(32'h3);
    idle(2);
    check("st_xfer", xfer_count, 32'd3);
    check("st_stall", stall_count, 32'd4);
    flush = 1;
    idle(1);
    flush = 0;
    check("st_fl_xfer", xfer_count, 32'd3);
    check("st_fl_stall", stall_count, 32'd4);
`endif
    idle(2);
    check("final_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
